// File: rtl/game_tick_pkg.sv
// Shared types and default constants for the game timing generator.
package game_tick_pkg;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    PAUSE_PEND  = 2'd1,
    PAUSED      = 2'd2,
    RESUME_PEND = 2'd3
  } state_t;

  localparam int DEF_MOVE_DIV   = 4;
  localparam int DEF_BULLET_DIV = 2;
  localparam int DEF_FRAME_W    = 16;

  // Counter width able to hold values 0..div-1, never narrower than 1 bit.
  function automatic int div_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/game_tick_gen_tick_edge_sync.sv
// Synchronizes a slow toggling divider output into clk and emits a registered
// one-cycle pulse on each rising edge; the first valid sample only primes.
module tick_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] valid_reg;
  logic                   prev_reg;
  logic                   primed_reg;
  logic                   sync_last;

  assign sync_last = sync_reg[SYNC_STAGES-1];

  // valid_reg marks when the chain holds real post-reset samples, so reset
  // zeros are never mistaken for a low level of the source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg   <= '0;
      valid_reg  <= '0;
      prev_reg   <= 1'b0;
      primed_reg <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[SYNC_STAGES-2:0], async_in};
      valid_reg  <= {valid_reg[SYNC_STAGES-2:0], 1'b1};
      edge_pulse <= 1'b0;
      if (valid_reg[SYNC_STAGES-1]) begin
        prev_reg   <= sync_last;
        primed_reg <= 1'b1;
        edge_pulse <= primed_reg & sync_last & ~prev_reg;
      end
    end
  end

endmodule

// File: rtl/game_tick_gen.sv
// Game timing strobes derived from the 60 Hz divider output, with a
// frame-aligned pause/resume FSM. Optional watchdog: GAME_TICK_WATCHDOG_EN.
module game_tick_gen
  import game_tick_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MOVE_DIV    = DEF_MOVE_DIV,
  parameter int BULLET_DIV  = DEF_BULLET_DIV,
  parameter int FRAME_W     = DEF_FRAME_W,
  parameter int WDOG_LIMIT  = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_60Hz,
  input  logic               pause_req,
  input  logic               resume_req,
  output logic               paused,
  output logic               frame_tick,
  output logic               move_tick,
  output logic               bullet_tick,
  output logic [FRAME_W-1:0] frame_count,
  output logic               stall
);

  localparam int MOVE_W   = div_width(MOVE_DIV);
  localparam int BULLET_W = div_width(BULLET_DIV);

  logic                edge_pulse;
  logic                emit;
  state_t              state_reg;
  state_t              state_next;
  logic [MOVE_W-1:0]   move_cnt;
  logic [BULLET_W-1:0] bullet_cnt;
  logic                move_wrap;
  logic                bullet_wrap;

  tick_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk        (clk),
    .rst        (rst),
    .async_in   (clk_60Hz),
    .edge_pulse (edge_pulse)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= RUN;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    emit       = 1'b0;
    case (state_reg)
      RUN: begin
        emit = edge_pulse;
        if (pause_req) state_next = PAUSE_PEND;
      end
      PAUSE_PEND: begin
        if (edge_pulse) state_next = PAUSED;
      end
      PAUSED: begin
        if (resume_req && !pause_req) state_next = RESUME_PEND;
      end
      RESUME_PEND: begin
        // A pause arriving together with the edge cancels the resume outright.
        if (pause_req) begin
          state_next = PAUSED;
        end else if (edge_pulse) begin
          emit       = 1'b1;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  assign move_wrap   = (move_cnt == MOVE_W'(MOVE_DIV - 1));
  assign bullet_wrap = (bullet_cnt == BULLET_W'(BULLET_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      paused      <= 1'b0;
      frame_tick  <= 1'b0;
      move_tick   <= 1'b0;
      bullet_tick <= 1'b0;
      frame_count <= '0;
      move_cnt    <= '0;
      bullet_cnt  <= '0;
    end else begin
      paused      <= (state_next == PAUSED) || (state_next == RESUME_PEND);
      frame_tick  <= emit;
      move_tick   <= emit & move_wrap;
      bullet_tick <= emit & bullet_wrap;
      if (emit) begin
        frame_count <= frame_count + FRAME_W'(1);
        move_cnt    <= move_wrap ? '0 : move_cnt + MOVE_W'(1);
        bullet_cnt  <= bullet_wrap ? '0 : bullet_cnt + BULLET_W'(1);
      end
    end
  end

`ifdef GAME_TICK_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);

  logic [WDOG_W-1:0] wdog_cnt;

  // Counts in every FSM state; saturates so stall holds until the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt <= '0;
      stall    <= 1'b0;
    end else if (edge_pulse) begin
      wdog_cnt <= '0;
      stall    <= 1'b0;
    end else if (wdog_cnt != WDOG_W'(WDOG_LIMIT)) begin
      wdog_cnt <= wdog_cnt + WDOG_W'(1);
      stall    <= (wdog_cnt + WDOG_W'(1)) == WDOG_W'(WDOG_LIMIT);
    end
  end
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_LIMIT;
  assign stall       = 1'b0;
`endif

endmodule
